lagarto_fp_mul_operand_check_pipe: RTL
======================================

# lagarto_fp_mul_operand_check_pipe

Pipelined, multi-format successor to the scalar FP multiplier operand checker, used in front of the vector FP multiplier lanes. Each 64-bit operand pair is classified as one FP64 element, two packed FP32 elements or four packed FP16 elements, selected per transaction. It produces per-lane special-case flags and result sign through a single registered valid/ready stage. It also keeps a sticky invalid-operation (NV) flag for the vector CSR path.

## Interface
- TAG_W, 8: width of the opaque transaction tag carried alongside the data.
- LANES, 4: maximum lanes per word. Fixed at 4 (FP16 packing); it is a parameter only for the port widths.
- clk_i  in  1  clock; all state updates on the rising edge.
- rstn_i  in  1  reset; asynchronous, active-low.
- valid_i  in  1  input transaction valid.
- ready_o  out  1  input can be accepted this cycle.
- fmt_i  in  2  element format: 00 FP16, 01 FP32, 10 FP64, 11 illegal.
- mask_i  in  LANES  per-lane enable; disabled lanes report all-zero flags.
- operand_a_i, operand_b_i  in  64  packed operands. FP32 lane k uses bits [32k+31:32k]; FP16 lane k uses bits [16k+15:16k]; FP64 uses lane 0.
- tag_i  in  TAG_W  transaction tag.
- flush_i  in  1  discard the held output transaction.
- clear_nv_i  in  1  clear the sticky NV flag.
- valid_o  out  1  output transaction valid.
- ready_i  in  1  downstream accepts output.
- lane_active_o  out  LANES  lanes that are in-format and unmasked.
- invalid_o  out  LANES  per lane: sNaN on either operand, or zero×inf.
- nan_o  out  LANES  per lane: result is the canonical qNaN (any NaN input or zero×inf).
- zero_o  out  LANES  per lane: result is ±0 (a zero operand, no inf on the other operand, no NaN).
- inf_o  out  LANES  per lane: result is ±inf (an inf operand, no zero on the other operand, no NaN).
- subnormal_o  out  LANES  per lane: either operand is subnormal.
- sign_o  out  LANES  per lane: sign_a XOR sign_b.
- illegal_fmt_o  out  1  the held transaction had fmt 11.
- tag_o  out  TAG_W  held tag.
- nv_sticky_o  out  1  sticky OR of invalid_o over retired transactions.

## Operation
- Per lane, using the format's exponent and mantissa fields:
  - qNaN: exponent all ones and mantissa MSB = 1.
  - sNaN: exponent all ones, mantissa MSB = 0 and the rest of the mantissa non-zero.
  - inf: exponent all ones, mantissa = 0.
  - zero: exponent = 0, mantissa = 0.
  - subnormal: exponent = 0, mantissa non-zero.
- Field widths: FP64 e11/m52, FP32 e8/m23, FP16 e5/m10.
- Lane activity: FP64 lane 0 only, FP32 lanes 0–1, FP16 lanes 0–3, each ANDed with mask_i. fmt 11 makes no lane active and sets illegal_fmt.
- Every per-lane output is forced to 0 on inactive lanes, including sign_o.
- nan_o, zero_o and inf_o are mutually exclusive per lane. Neither NaN flag is asserted on an inf×inf product.
- Classification is combinational on the inputs. The results are captured in the output register on acceptance (valid_i && ready_o).
- Sticky NV: on output retirement (valid_o && ready_i), nv <= nv_base | (|invalid_o).
  - nv_base is 0 when clear_nv_i is asserted that cycle, otherwise the current nv.
  - clear_nv_i without a retirement sets nv to 0.
  - Flushed transactions never update nv.

## Timing
- Latency is 1 cycle: a transaction accepted at edge N is presented on valid_o after edge N.
- ready_o = !valid_o || ready_i, combinational. This allows full throughput, one transaction per cycle, under continuous ready.
- While valid_o && !ready_i, all outputs except nv_sticky_o hold stable.
- flush_i: valid_o goes to 0 next edge and any accept in the same cycle is dropped. ready_o is unaffected by flush in the same cycle.
- Reset (async assert, any time including mid-transaction): valid_o=0, nv_sticky_o=0, and all flag, sign, tag and illegal_fmt registers are 0. ready_o=1 while rstn_i is low and after release.

## Structure
- Shared package (lagarto_fpu_pkg) holds:
  - fmt encoding enum (FMT_FP16, FMT_FP32, FMT_FP64, FMT_ILLEGAL);
  - per-format EXP_W/MAN_W constants;
  - the per-lane flag struct {invalid, nan, zero, inf, subnormal, sign}.
- One sub-module, lagarto_fp_mul_lane_classify, parametrised by EXP_W/MAN_W. It is instantiated for FP64 ×1, FP32 ×2 and FP16 ×4, with results muxed by fmt_i.

## Test plan
- FP64: a=0x0000000000000000, b=0x7FF0000000000000, mask=0001 -> next cycle valid_o=1, invalid_o=0001, nan_o=0001, zero_o=0, inf_o=0. After retirement nv_sticky_o=1.
- FP32: a=0x7F800001_3F800000, b=0x3F800000_80000000 -> lane1 invalid=1, nan=1; lane0 zero=1, sign=1; lane_active=0011.
- FP16: a=0x7E00_7C00_0001_0000, b=0x3C00_FC00_3C00_3C00, mask=1011 -> lane3 nan=1 with invalid=0; lane2 inactive (all 0); lane1 subnormal=1; lane0 zero=1.
- Backpressure: ready_i=0 for 3 cycles with valid_i held -> ready_o=0 and outputs stable. ready_i=1 -> retire, then the next transaction appears after the following edge.
- fmt_i=11 -> illegal_fmt_o=1, lane_active_o=0000. nv unchanged on retirement.
- Reset and flush cases:
  - Set nv, then assert clear_nv_i while retiring a non-invalid transaction -> nv_sticky_o=0.
  - Flush while holding an invalid transaction -> valid_o=0 and nv stays unchanged.
  - Assert rstn_i=0 mid-hold -> valid_o=0 immediately.

Source files
------------

// File: rtl/lagarto_fpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lagarto_fpu_pkg                                                 |
// | Brief    : Shared FP format encodings, field widths and lane flag struct.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package lagarto_fpu_pkg;

  typedef enum logic [1:0] {
    FMT_FP16    = 2'b00,
    FMT_FP32    = 2'b01,
    FMT_FP64    = 2'b10,
    FMT_ILLEGAL = 2'b11
  } fmt_e;

  localparam int FP64_EXP_W = 11;
  localparam int FP64_MAN_W = 52;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;

  typedef struct packed {
    logic invalid;
    logic nan;
    logic zero;
    logic inf;
    logic subnormal;
    logic sign;
  } lane_flags_t;

endpackage
`default_nettype wire

// File: rtl/lagarto_fp_mul_lane_classify.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lagarto_fp_mul_lane_classify                                    |
// | Brief    : Special-case classification of one multiplier operand pair.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module lagarto_fp_mul_lane_classify
  import lagarto_fpu_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
) (
  input  logic [EXP_W+MAN_W:0] operand_a,
  input  logic [EXP_W+MAN_W:0] operand_b,
  output lane_flags_t          flags
);

  localparam int c_w = EXP_W + MAN_W + 1;

  logic [EXP_W-1:0] w_exp_a, w_exp_b;
  logic [MAN_W-1:0] w_man_a, w_man_b;
  logic w_a_ones, w_a_ezero, w_a_mzero, w_b_ones, w_b_ezero, w_b_mzero;
  logic w_a_nan, w_a_snan, w_a_inf, w_a_zero, w_a_sub;
  logic w_b_nan, w_b_snan, w_b_inf, w_b_zero, w_b_sub;
  logic w_any_nan, w_zero_inf;

  assign w_exp_a   = operand_a[c_w-2 -: EXP_W];
  assign w_exp_b   = operand_b[c_w-2 -: EXP_W];
  assign w_man_a   = operand_a[MAN_W-1:0];
  assign w_man_b   = operand_b[MAN_W-1:0];

  assign w_a_ones  = &w_exp_a;
  assign w_a_ezero = ~|w_exp_a;
  assign w_a_mzero = ~|w_man_a;
  assign w_b_ones  = &w_exp_b;
  assign w_b_ezero = ~|w_exp_b;
  assign w_b_mzero = ~|w_man_b;

  // Signalling NaN: quiet bit clear with a non-zero payload below it.
  assign w_a_nan   = w_a_ones & ~w_a_mzero;
  assign w_a_snan  = w_a_ones & ~w_man_a[MAN_W-1] & (|w_man_a[MAN_W-2:0]);
  assign w_a_inf   = w_a_ones & w_a_mzero;
  assign w_a_zero  = w_a_ezero & w_a_mzero;
  assign w_a_sub   = w_a_ezero & ~w_a_mzero;

  assign w_b_nan   = w_b_ones & ~w_b_mzero;
  assign w_b_snan  = w_b_ones & ~w_man_b[MAN_W-1] & (|w_man_b[MAN_W-2:0]);
  assign w_b_inf   = w_b_ones & w_b_mzero;
  assign w_b_zero  = w_b_ezero & w_b_mzero;
  assign w_b_sub   = w_b_ezero & ~w_b_mzero;

  assign w_any_nan  = w_a_nan | w_b_nan;
  assign w_zero_inf = (w_a_zero & w_b_inf) | (w_a_inf & w_b_zero);

  assign flags.invalid   = w_a_snan | w_b_snan | w_zero_inf;
  assign flags.nan       = w_any_nan | w_zero_inf;
  assign flags.zero      = (w_a_zero | w_b_zero) & ~w_a_inf & ~w_b_inf & ~w_any_nan;
  assign flags.inf       = (w_a_inf | w_b_inf) & ~w_a_zero & ~w_b_zero & ~w_any_nan;
  assign flags.subnormal = w_a_sub | w_b_sub;
  assign flags.sign      = operand_a[c_w-1] ^ operand_b[c_w-1];

endmodule
`default_nettype wire

// File: rtl/lagarto_fp_mul_operand_check_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lagarto_fp_mul_operand_check_pipe                               |
// | Brief    : Multi-format FP multiplier operand checker, one register stage. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module lagarto_fp_mul_operand_check_pipe
  import lagarto_fpu_pkg::*;
#(
  parameter int TAG_W = 8,
  parameter int LANES = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       fmt_i,
  input  logic [LANES-1:0] mask_i,
  input  logic [63:0]      operand_a_i,
  input  logic [63:0]      operand_b_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  input  logic             clear_nv_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [LANES-1:0] lane_active_o,
  output logic [LANES-1:0] invalid_o,
  output logic [LANES-1:0] nan_o,
  output logic [LANES-1:0] zero_o,
  output logic [LANES-1:0] inf_o,
  output logic [LANES-1:0] subnormal_o,
  output logic [LANES-1:0] sign_o,
  output logic             illegal_fmt_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             nv_sticky_o
);

  lane_flags_t             w_fp64_flags;
  lane_flags_t [1:0]       w_fp32_flags;
  lane_flags_t [3:0]       w_fp16_flags;
  lane_flags_t [LANES-1:0] w_raw_flags;
  logic [LANES-1:0]        w_fmt_lanes, w_active;
  logic [LANES-1:0]        w_invalid, w_nan, w_zero, w_inf, w_sub, w_sign;
  logic                    w_illegal, w_accept, w_retire;

  logic                    r_valid, r_illegal, r_nv;
  logic [TAG_W-1:0]        r_tag;
  logic [LANES-1:0]        r_active, r_invalid, r_nan, r_zero, r_inf, r_sub, r_sign;

  lagarto_fp_mul_lane_classify #(.EXP_W(FP64_EXP_W), .MAN_W(FP64_MAN_W)) u_fp64 (
    .operand_a (operand_a_i),
    .operand_b (operand_b_i),
    .flags     (w_fp64_flags)
  );

  for (genvar k = 0; k < 2; k++) begin : g_fp32
    lagarto_fp_mul_lane_classify #(.EXP_W(FP32_EXP_W), .MAN_W(FP32_MAN_W)) u_fp32 (
      .operand_a (operand_a_i[32*k +: 32]),
      .operand_b (operand_b_i[32*k +: 32]),
      .flags     (w_fp32_flags[k])
    );
  end

  for (genvar k = 0; k < 4; k++) begin : g_fp16
    lagarto_fp_mul_lane_classify #(.EXP_W(FP16_EXP_W), .MAN_W(FP16_MAN_W)) u_fp16 (
      .operand_a (operand_a_i[16*k +: 16]),
      .operand_b (operand_b_i[16*k +: 16]),
      .flags     (w_fp16_flags[k])
    );
  end

  always_comb begin
    w_raw_flags = '0;
    w_fmt_lanes = '0;
    w_illegal   = 1'b0;
    case (fmt_e'(fmt_i))
      FMT_FP16: begin
        w_raw_flags[3:0] = w_fp16_flags;
        w_fmt_lanes      = LANES'(4'b1111);
      end
      FMT_FP32: begin
        w_raw_flags[1:0] = w_fp32_flags;
        w_fmt_lanes      = LANES'(2'b11);
      end
      FMT_FP64: begin
        w_raw_flags[0]   = w_fp64_flags;
        w_fmt_lanes      = LANES'(1'b1);
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Inactive lanes report nothing at all, sign included.
  always_comb begin
    w_active  = w_fmt_lanes & mask_i;
    w_invalid = '0;
    w_nan     = '0;
    w_zero    = '0;
    w_inf     = '0;
    w_sub     = '0;
    w_sign    = '0;
    for (int l = 0; l < LANES; l++) begin
      w_invalid[l] = w_active[l] & w_raw_flags[l].invalid;
      w_nan[l]     = w_active[l] & w_raw_flags[l].nan;
      w_zero[l]    = w_active[l] & w_raw_flags[l].zero;
      w_inf[l]     = w_active[l] & w_raw_flags[l].inf;
      w_sub[l]     = w_active[l] & w_raw_flags[l].subnormal;
      w_sign[l]    = w_active[l] & w_raw_flags[l].sign;
    end
  end

  assign ready_o  = ~r_valid | ready_i;
  assign w_accept = valid_i & ready_o;
  // A flushed transaction is discarded, never retired.
  assign w_retire = r_valid & ready_i & ~flush_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_nv      <= 1'b0;
      r_tag     <= '0;
      r_active  <= '0;
      r_invalid <= '0;
      r_nan     <= '0;
      r_zero    <= '0;
      r_inf     <= '0;
      r_sub     <= '0;
      r_sign    <= '0;
    end else begin
      if (flush_i)       r_valid <= 1'b0;
      else if (w_accept) r_valid <= 1'b1;
      else if (ready_i)  r_valid <= 1'b0;

      if (w_accept && !flush_i) begin
        r_illegal <= w_illegal;
        r_tag     <= tag_i;
        r_active  <= w_active;
        r_invalid <= w_invalid;
        r_nan     <= w_nan;
        r_zero    <= w_zero;
        r_inf     <= w_inf;
        r_sub     <= w_sub;
        r_sign    <= w_sign;
      end

      if (w_retire)        r_nv <= (r_nv & ~clear_nv_i) | (|r_invalid);
      else if (clear_nv_i) r_nv <= 1'b0;
    end
  end

  assign valid_o       = r_valid;
  assign illegal_fmt_o = r_illegal;
  assign tag_o         = r_tag;
  assign lane_active_o = r_active;
  assign invalid_o     = r_invalid;
  assign nan_o         = r_nan;
  assign zero_o        = r_zero;
  assign inf_o         = r_inf;
  assign subnormal_o   = r_sub;
  assign sign_o        = r_sign;
  assign nv_sticky_o   = r_nv;

endmodule
`default_nettype wire
